// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display driver.
package display_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned IDX_W = 2;

  // Active-low {g,f,e,d,c,b,a} codes
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

  localparam logic [IDX_W-1:0] DIG_ONES  = 2'd0;
  localparam logic [IDX_W-1:0] DIG_TENS  = 2'd1;
  localparam logic [IDX_W-1:0] DIG_HUNDS = 2'd2;
  localparam logic [IDX_W-1:0] DIG_SIGN  = 2'd3;

  localparam logic [AN_W-1:0] AN_OFF = 4'b1111;

  typedef struct packed {
    logic             sign;
    logic [NIB_W-1:0] hunds;
    logic [NIB_W-1:0] tens;
    logic [NIB_W-1:0] ones;
  } disp_val_t;

  // One-hot active-low anode pattern for a digit index
  function automatic logic [AN_W-1:0] an_sel(input logic [IDX_W-1:0] idx);
    return ~(AN_W'(1) << idx);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low seven-segment code with blank/minus overrides.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  input  logic             blank,
  input  logic             minus,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_E;
    if (blank) begin
      seg_c = SEG_BLANK;
    end else if (minus) begin
      seg_c = SEG_MINUS;
    end else begin
      case (nibble)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Time-multiplexed 4-digit common-anode display driver for a signed 3-digit BCD value.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros on the hundreds/tens digits.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] bcd_in,
  input  logic        sign_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  disp_val_t        val;

  logic [NIB_W-1:0] dig_nib;
  logic             dig_blank;
  logic             dig_minus;
  logic [SEG_W-1:0] dig_seg_c;

  // Select the nibble and blank/minus overrides for the current digit
  always_comb begin
    dig_nib   = '0;
    dig_blank = 1'b0;
    dig_minus = 1'b0;
    case (idx)
      DIG_ONES: dig_nib = val.ones;
      DIG_TENS: begin
        dig_nib = val.tens;
`ifdef LEADING_ZERO_BLANK_EN
        dig_blank = (val.hunds == '0) && (val.tens == '0);
`endif
      end
      DIG_HUNDS: begin
        dig_nib = val.hunds;
`ifdef LEADING_ZERO_BLANK_EN
        dig_blank = (val.hunds == '0);
`endif
      end
      default: begin
        dig_minus = val.sign;
        dig_blank = ~val.sign;
      end
    endcase
  end

  seg7_decoder u_dec (
    .nibble (dig_nib),
    .blank  (dig_blank),
    .minus  (dig_minus),
    .seg_c  (dig_seg_c)
  );

  // Refresh counter, digit index, holding register and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= DIG_ONES;
      val <= '0;
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load) begin
        val <= disp_val_t'({sign_in, bcd_in});
      end
      an  <= an_sel(idx);
      seg <= dig_seg_c;
      dp  <= 1'b1;
    end
  end

endmodule

// File: doc/bcd_display_driver.md
# bcd_display_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display on the lab board. It sits directly downstream of the binary-to-BCD converter and takes the 12-bit, 3-digit BCD result of the ALU plus a sign flag. It latches that value on a load strobe and scans the digits continuously, one anode at a time, with registered active-low outputs.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays lit (1 kHz digit rate at 100 MHz); legal range ≥ 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle strobe; captures bcd_in and sign_in.
- bcd_in  in  12  {hundreds, tens, ones} BCD nibbles.
- sign_in  in  1  1 = show minus sign on digit 3.
- an  out  4  anode enables, active-low; an[0] = rightmost (ones).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; constant 1 (off) after reset.

## Operation
- Holding register val[12:0] = {sign, bcd}; written at any edge with load=1; reset value 0.
- Refresh counter cnt counts 0..REFRESH_DIV-1 and wraps. Digit index idx (2 bits) advances 0→1→2→3→0 at the edge where cnt = REFRESH_DIV-1.
- Digit source per idx: 0 = ones, 1 = tens, 2 = hundreds, 3 = sign.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111, E=0000110
- Nibble > 9 (invalid BCD): display E; it never counts as zero for blanking.
- Digit 3: minus if sign, else blank.
- an is one-hot low at bit idx; no two anodes are ever low together.
- Load during a lit slot: the new value appears on the next registered output update. Displayed digits never mix old and new values within one slot after that update.
- Load coincident with an idx advance: both take effect, and the next slot shows the new value.
- Reset mid-scan: all state returns to reset values immediately (asynchronous).

## Timing
- Reset values: an=1111, seg=1111111, dp=1, idx=0, cnt=0, val=0.
- First edge after rst deasserts: an=1110, seg=code of val ones (0 → 1000000).
- an and seg are registered from idx and val: 1-cycle latency from idx change or load to the outputs.
- Each anode is low for exactly REFRESH_DIV consecutive cycles. A full scan takes 4·REFRESH_DIV cycles.
- load has no backpressure and is accepted every cycle. If load is held high, the last sampled value wins.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - hundreds is blank when it equals 0.
  - tens is blank when both hundreds and tens equal 0.
  - ones is never blanked.
  - sign digit behaviour is unchanged.
- LEADING_ZERO_BLANK_EN undefined: all three BCD digits are always shown, e.g. 007.

## Structure
- Shared package/include display_pkg:
  - segment code constants (digits 0–9, minus, blank, E).
  - digit-index encoding.
  - anode-off constant 4'b1111.
- Sub-module seg7_decoder: combinational, 4-bit nibble plus blank/minus controls to a 7-bit active-low code; E for invalid nibbles.
- Top level holds cnt, idx, val, blanking logic and output registers.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset, then no load: outputs 1111/1111111 during reset. Afterwards an scans 1110,1101,1011,0111, 4 cycles each.
  - Without the macro, seg=1000000 on the three numeric digits.
  - With the macro, only the ones digit shows 1000000.
- load with bcd_in=12'h255, sign_in=0 → over one scan, seg = 0010010 (ones), 0010010 (tens), 0100100 (hundreds), 1111111 (sign digit).
- load with bcd_in=12'h007, sign_in=1 → with the macro, seg = 1111000, blank, blank, 0111111. Without the macro, seg = 1111000, 1000000, 1000000, 0111111.
- load with bcd_in=12'h0A3 → tens digit shows 0000110 (E). Hundreds stays blank with the macro; the invalid tens digit is not blanked.
- load asserted on the same edge idx advances, 12'h123 replacing 12'h456 → the new slot shows the new value from its first registered output.
- rst pulsed mid-slot while an=1011 → an=1111 and seg=1111111 immediately. After release, the scan restarts at an=1110 and val=0.
